// File: rtl/lane_gene_pkg.sv
// Shared gene layout, identifiers, LFSR constants and sequencer state encoding
// for the genome-lane add-node mutation path.
package lane_gene_pkg;

  localparam int unsigned GENE_SZ = 64;
  localparam int unsigned ATTR_SZ = 8;
  localparam int unsigned CNT_W   = 16;

  localparam int unsigned GID_LSB  = 56;
  localparam int unsigned ID_LSB   = 48;
  localparam int unsigned SRC_LSB  = 40;
  localparam int unsigned DEST_LSB = 32;
  localparam int unsigned WGT_LSB  = 24;
  localparam int unsigned EN_LSB   = 16;

  localparam logic [ATTR_SZ-1:0] ID_NODE      = 8'h00;
  localparam logic [ATTR_SZ-1:0] ID_CONN      = 8'h80;
  localparam logic [ATTR_SZ-1:0] DEFAULT_ATTR = 8'h01;
  localparam logic [ATTR_SZ-1:0] MAX_ID       = 8'hFF;

  // Right-shifting Fibonacci form of x^16+x^14+x^13+x^11+1: feedback from bits 0,2,3,5
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

  typedef enum logic [2:0] {IDLE, PASS, ORIG, NODE, C1, C2} state_e;

endpackage

// File: rtl/add_node_mutation.sv
// Forms the new node gene, the first replacement connection, and the header
// half of the second replacement connection for an add-node split.
module add_node_mutation
  import lane_gene_pkg::*;
(
  input  logic [ATTR_SZ-1:0] genome_id_i,
  input  logic [ATTR_SZ-1:0] src_i,
  input  logic [ATTR_SZ-1:0] dest_i,
  input  logic [31:0]        tail_i,
  input  logic [ATTR_SZ-1:0] max_node_id_i,
  output logic [GENE_SZ-1:0] node_gene_o,
  output logic [GENE_SZ-1:0] c1_gene_o,
  output logic [31:0]        c2_hdr_o
);

  logic [ATTR_SZ-1:0] new_id;

  always_comb begin
    new_id      = max_node_id_i + 8'd1;
    node_gene_o = {genome_id_i, ID_NODE, new_id, 8'h00,
                   DEFAULT_ATTR, DEFAULT_ATTR, DEFAULT_ATTR, DEFAULT_ATTR};
    c1_gene_o   = {genome_id_i, ID_CONN, src_i, new_id, tail_i};
    c2_hdr_o    = {genome_id_i, ID_CONN, new_id, dest_i};
  end

endmodule

// File: rtl/lane_mutation_sched.sv
// Add-node mutation sequencer: LFSR-driven split decision per connection gene,
// emitting ORIG/NODE/C1/C2 beats for splits and passing other genes through.
module lane_mutation_sched
  import lane_gene_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_load,
  input  logic [ATTR_SZ-1:0] cfg_max_node_id,
  input  logic [ATTR_SZ-1:0] cfg_rate,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [GENE_SZ-1:0] in_gene,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [GENE_SZ-1:0] out_gene,
  output logic [ATTR_SZ-1:0] max_node_id,
  output logic [CNT_W-1:0]   mut_count,
  output logic               id_sat
);

  state_e             state_q;
  logic               out_valid_q;
  logic [GENE_SZ-1:0] out_gene_q;
  logic [ATTR_SZ-1:0] gid_q, src_q, dest_q, new_id_q, max_id_q;
  logic [31:0]        tail_q;
  logic [CNT_W-1:0]   mut_q;
  logic               sat_q;
  logic [15:0]        lfsr_q, lfsr_d;

  logic               accept, eligible, split;
  logic [ATTR_SZ-1:0] prev_id;
  logic [GENE_SZ-1:0] node_gene, c1_gene;
  logic [31:0]        c2_hdr;

  always_comb begin
    in_ready = 1'b0;
    unique case (state_q)
      IDLE:    in_ready = !cfg_load;
      PASS:    in_ready = out_ready;
      default: in_ready = 1'b0;
    endcase
    accept   = in_valid && in_ready;
    eligible = in_gene[ID_LSB+7] && (lfsr_q[7:0] < cfg_rate);
    split    = eligible && (max_id_q != MAX_ID);
    lfsr_d   = {^(lfsr_q & LFSR_TAPS), lfsr_q[15:1]};
    prev_id  = new_id_q - 8'd1;
  end

  add_node_mutation u_add_node (
    .genome_id_i   (gid_q),
    .src_i         (src_q),
    .dest_i        (dest_q),
    .tail_i        (tail_q),
    .max_node_id_i (prev_id),
    .node_gene_o   (node_gene),
    .c1_gene_o     (c1_gene),
    .c2_hdr_o      (c2_hdr)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      out_gene_q  <= '0;
      gid_q       <= '0;
      src_q       <= '0;
      dest_q      <= '0;
      tail_q      <= '0;
      new_id_q    <= '0;
      max_id_q    <= '0;
      mut_q       <= '0;
      sat_q       <= 1'b0;
      lfsr_q      <= LFSR_SEED;
    end else begin
      unique case (state_q)
        IDLE: if (cfg_load) max_id_q <= cfg_max_node_id;
        PASS: if (out_ready) begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
        end
        ORIG: if (out_ready) begin
          state_q    <= NODE;
          out_gene_q <= node_gene;
        end
        NODE: if (out_ready) begin
          state_q    <= C1;
          out_gene_q <= c1_gene;
        end
        C1: if (out_ready) begin
          state_q    <= C2;
          out_gene_q <= {c2_hdr, DEFAULT_ATTR, DEFAULT_ATTR, 16'h0000};
        end
        C2: if (out_ready) begin
          state_q     <= IDLE;
          out_valid_q <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
      // An accept (IDLE, or PASS with a handshake) overrides the case-branch outcome
      if (accept) begin
        lfsr_q      <= lfsr_d;
        out_valid_q <= 1'b1;
        gid_q       <= in_gene[GID_LSB +: ATTR_SZ];
        src_q       <= in_gene[SRC_LSB +: ATTR_SZ];
        dest_q      <= in_gene[DEST_LSB +: ATTR_SZ];
        tail_q      <= in_gene[31:0];
        if (split) begin
          state_q    <= ORIG;
          out_gene_q <= {in_gene[63:24], 8'h00, in_gene[15:0]};
          new_id_q   <= max_id_q + 8'd1;
          max_id_q   <= max_id_q + 8'd1;
          if (mut_q != '1) mut_q <= mut_q + 16'd1;
        end else begin
          state_q    <= PASS;
          out_gene_q <= in_gene;
          if (eligible) sat_q <= 1'b1;
        end
      end
    end
  end

  assign out_valid   = out_valid_q;
  assign out_gene    = out_gene_q;
  assign max_node_id = max_id_q;
  assign mut_count   = mut_q;
  assign id_sat      = sat_q;

endmodule

// File: doc/lane_mutation_sched.md
# lane_mutation_sched

Sequencing controller for the add-node mutation datapath in a genome lane. It consumes a stream of 64-bit genes and uses an internal LFSR against a programmable rate to decide whether each connection gene is split. For a split gene it emits the disabled original followed by the new node gene and the two replacement connection genes, and it keeps the lane's running `max_node_id`. It sits between the gene-memory read port and the gene-memory write/crossover stage.

## Interface
- `GENE_SZ`, 64, gene width
- `ATTR_SZ`, 8, attribute field width; gene = 8 fields
- `CNT_W`, 16, mutation counter width

- `clk` in 1: clock
- `rst` in 1: reset; synchronous and active-high (already decided)
- `cfg_load` in 1: load `cfg_max_node_id` into the node-ID register
- `cfg_max_node_id` in ATTR_SZ: initial highest node ID in the genome
- `cfg_rate` in ATTR_SZ: split threshold; 0 = never split
- `in_valid` in 1 / `in_ready` out 1 / `in_gene` in GENE_SZ: input gene stream
- `out_valid` out 1 / `out_ready` in 1 / `out_gene` out GENE_SZ: output gene stream
- `max_node_id` out ATTR_SZ: current highest node ID
- `mut_count` out CNT_W: number of splits committed, saturating
- `id_sat` out 1: sticky; a split was suppressed because `max_node_id` = 8'hFF

## Operation
- Gene field layout, MSB first:
  - [63:56] genome_id
  - [55:48] identifier: 8'h80 = connection, 8'h00 = node
  - [47:40] src / node_id
  - [39:32] dest
  - [31:24] weight / bias
  - [23:16] enable / response
  - [15:0] attributes
- LFSR: 16 bits, taps x^16+x^14+x^13+x^11+1, seed 16'hACE1 on reset. Steps once per accepted input gene only.
- Split decision at input accept: `split` = (`in_gene`[55] = 1) AND (`lfsr`[7:0] < `cfg_rate`) AND (`max_node_id` != 8'hFF).
  - If the first two terms hold but `max_node_id` = 8'hFF: no split, the gene passes through, `id_sat` is set.
- On split, latch the gene and `new_id` = `max_node_id`+1. In the same cycle, `max_node_id` <= `new_id` and `mut_count`++ (saturating).
- Split output sequence, 4 beats:
  - ORIG: the input gene with [23:16] = 8'h00.
  - NODE: {genome_id, 8'h00, new_id, 8'h00, 8'h01, 8'h01, 8'h01, 8'h01}.
  - C1: {genome_id, 8'h80, src, new_id, in[31:0]}.
  - C2: {genome_id, 8'h80, new_id, dest, 8'h01, 8'h01, 16'h0}.
- Non-split gene, node gene or not: passed unchanged in 1 beat.
- FSM states: IDLE, PASS, ORIG, NODE, C1, C2. `out_valid` = 1 in every state except IDLE.
  - IDLE: `in_ready` = !`cfg_load`. Accept -> PASS or ORIG.
  - PASS: `in_ready` = `out_ready`. Handshake with a new accept -> PASS or ORIG. Handshake without a new accept -> IDLE.
  - ORIG -> NODE -> C1 -> C2 -> IDLE, each step on `out_ready`. `in_ready` = 0 in these states.
- `cfg_load` is honoured only in IDLE and has priority over `in_valid` there. It does not clear `mut_count` or `id_sat`. `cfg_load` outside IDLE is ignored.
- `out_gene` is stable while `out_valid` && !`out_ready`.

## Timing
- Reset values: state IDLE, `out_valid` 0, `out_gene` 0, `max_node_id` 0, `mut_count` 0, `id_sat` 0, LFSR 16'hACE1. Reset mid-sequence abandons the remaining beats.
- Latency: a gene accepted in cycle N appears on `out_gene` in cycle N+1.
- Throughput: 1 gene/cycle for non-split streams with `out_ready` held high. A split occupies the output for 4 handshakes.
- `max_node_id`/`mut_count` update in the cycle after the accept, before NODE is emitted.
- `in_ready` is combinational from state and `out_ready`. No other combinational input-to-output paths.

## Structure
- Package `lane_gene_pkg`: ATTR_SZ/GENE_SZ, field bit positions, ID_NODE = 8'h00, ID_CONN = 8'h80, DEFAULT_ATTR = 8'h01, LFSR seed and taps, state enum.
- One sub-module: `add_node_mutation` instantiated for node/C1 gene formation with `max_node_id` = latched `new_id`-1. This block drives C2 bits [31:0] itself to {8'h01, 8'h01, 16'h0} regardless of sub-module output.
- LFSR and FSM stay inline.

## Test plan
- `cfg_rate`=0, 10 connection genes, `out_ready`=1 -> identical 10 genes out, one per cycle, `mut_count`=0.
- `cfg_load` with 8'h05, `cfg_rate`=8'hFF, in = 64'h0380_0102_1F01_0000 with LFSR low byte < 8'hFF -> beats:
  - 64'h0380_0102_1F00_0000
  - 64'h0300_0600_0101_0101
  - 64'h0380_0106_1F01_0000
  - 64'h0380_0602_0101_0000
  - then `max_node_id`=6, `mut_count`=1.
- Node gene (id 8'h00) with `cfg_rate`=8'hFF -> passes unchanged, LFSR steps, no split.
- `max_node_id`=8'hFF, split-eligible gene -> pass-through, `id_sat`=1, `max_node_id` stays 8'hFF.
- `out_ready` toggled randomly during a split -> each beat held stable, order preserved, `in_ready`=0 until C2 accepted.
- `rst` asserted during NODE beat -> next cycle all outputs at reset values. `cfg_load` during C1 -> ignored.
